mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle control unit that sequences the instruction-fetch datapath (PC, NPC calculator, instruction memory), the register file, the ALU and the data memory for the MIPS subset addu, subu, ori, lw, sw, beq, lui and j.
- A state machine steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- The unit gates PC update and instruction-register load, drives the npc_sel / is_jump controls consumed by the NPC calculator, and counts retired instructions.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0: 1 = an illegal opcode parks the FSM in HALT until reset; 0 = it is skipped like a NOP.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ins  input  32  instruction-register contents (opcode ins[31:26], funct ins[5:0]).
- alu_zero  input  1  ALU equality flag, valid in EXEC.
- ir_wr  output  1  load instruction register.
- pc_wr  output  1  PC update enable; one pulse per retired instruction.
- npc_sel  output  1  beq branch select to the NPC calculator.
- is_jump  output  1  j select to the NPC calculator.
- reg_wr  output  1  register-file write enable.
- reg_dst  output  1  1 = rd (R-type), 0 = rt.
- alu_src  output  1  1 = extended immediate, 0 = rt.
- alu_op  output  2  00 add, 01 sub, 10 or, 11 lui (imm<<16).
- ext_op  output  1  1 = sign-extend, 0 = zero-extend imm16.
- mem_wr  output  1  data-memory write enable.
- mem_to_reg  output  1  1 = write-back from memory.
- illegal  output  1  sticky unsupported-opcode flag.
- halted  output  1  FSM is in HALT.
- retired  output  CNT_W  count of retired instructions, wraps at 2^CNT_W.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT; state is registered and outputs are decoded combinationally from state and ins.
- Reset (async, any time including mid-instruction): state=FETCH, illegal=0, retired=0. All outputs are forced 0 while rst=1. The first FETCH begins on the first edge after rst falls.
- FETCH: ir_wr=1. Next state DECODE.
- DECODE, per opcode:
  - j (000010): is_jump=1, pc_wr=1, go to FETCH. Total 2 cycles.
  - Illegal opcode, or R-type with funct not 100001/100011: set illegal. If HALT_ON_ILLEGAL=0: pc_wr=1, go to FETCH. Otherwise go to HALT with no pc_wr.
  - All others go to EXEC.
- EXEC:
  - R-type: alu_src=0; alu_op=00 for addu, 01 for subu.
  - ori: alu_src=1, ext_op=0, alu_op=10.
  - lui: alu_src=1, alu_op=11.
  - lw/sw: alu_src=1, ext_op=1, alu_op=00.
  - beq: alu_op=01, npc_sel=1, pc_wr=1, go to FETCH (3 cycles). The branch is taken by the NPC calculator only if alu_zero=1; the controller does not inspect alu_zero.
  - lw/sw go to MEM; R-type, ori and lui go to WB.
  - ALU controls stay held through MEM and WB.
- MEM:
  - sw: mem_wr=1, pc_wr=1, go to FETCH (4 cycles).
  - lw: go to WB.
- WB: reg_wr=1, pc_wr=1, and go to FETCH.
  - reg_dst=1 only for R-type.
  - mem_to_reg=1 only for lw.
  - R-type, ori and lui take 4 cycles; lw takes 5.
- Cycle counts per instruction: j 2, beq 3, R-type/ori/lui 4, sw 4, lw 5.
- HALT: all enables 0, halted=1, stays until rst.
- retired increments on every edge where pc_wr=1, including a skipped illegal. It wraps to 0 after all-ones.
- Exactly one of pc_wr pulses per instruction. reg_wr and mem_wr are never simultaneously 1. Unlisted outputs are 0 in every state.
- ins must be stable from DECODE to the end of the instruction; the controller never reloads it outside FETCH.

Test Plan:
- Reset then addu $3,$1,$2 (0x00221821) -> ir_wr, then DECODE, EXEC (alu_op=00, alu_src=0), WB (reg_wr=1, reg_dst=1, pc_wr=1); retired=1 after 4 cycles.
- lw $4,8($0) (0x8C040008) -> 5 cycles; ext_op=1 in EXEC, mem_to_reg=1 and reg_wr=1 in WB; sw 0xAC040008 -> mem_wr=1 in MEM, 4 cycles, reg_wr never 1.
- beq 0x10220003 with alu_zero=0 and with alu_zero=1 -> in both cases npc_sel=1 and pc_wr=1 in EXEC, 3 cycles; j 0x08000C05 -> is_jump=1 and pc_wr=1 in DECODE, 2 cycles.
- ori 0x3421FFFF -> ext_op=0, alu_op=10; lui 0x3C011234 -> alu_op=11; both reg_dst=0.
- Opcode 0x3F, HALT_ON_ILLEGAL=0 -> illegal=1 sticky, pc_wr in DECODE, retired increments; with HALT_ON_ILLEGAL=1 -> halted=1, no pc_wr, held for 20 cycles until rst.
- Assert rst during lw MEM -> outputs 0 immediately; after release FETCH with ir_wr=1, retired=0. With CNT_W=2, retire 5 instructions -> retired=1.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with a retired-instruction counter.
// Latency: 2-5 cycles per instruction; no backpressure, so ins must stay stable until the instruction retires.
module mc_controller #(
    parameter int CNT_W           = 32,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins,
    input  logic             alu_zero,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             npc_sel,
    output logic             is_jump,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             ext_op,
    output logic             mem_wr,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic is_r, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_legal;

    logic ir_wr_c, pc_wr_c, npc_sel_c, is_jump_c, reg_wr_c, reg_dst_c;
    logic alu_src_c, ext_op_c, mem_wr_c, mem_to_reg_c, illegal_set;
    logic [1:0] alu_op_c;

    // Branch resolution belongs to the NPC calculator; only the immediate/rs/rt fields pass through untouched.
    logic unused_inputs;
    assign unused_inputs = ^{ins[25:6], alu_zero};

    assign opcode   = ins[31:26];
    assign funct    = ins[5:0];
    assign is_r     = (opcode == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
    assign is_subu  = (funct == FN_SUBU);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_r | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (illegal_set) begin
                illegal <= 1'b1;
            end
            if (pc_wr_c) begin
                retired <= retired + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ir_wr_c      = 1'b0;
        pc_wr_c      = 1'b0;
        npc_sel_c    = 1'b0;
        is_jump_c    = 1'b0;
        reg_wr_c     = 1'b0;
        reg_dst_c    = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = 2'b00;
        ext_op_c     = 1'b0;
        mem_wr_c     = 1'b0;
        mem_to_reg_c = 1'b0;
        illegal_set  = 1'b0;

        // ALU setup is held from EXEC through WB so the datapath result stays valid.
        if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
            if (is_r) begin
                alu_op_c = is_subu ? 2'b01 : 2'b00;
            end else if (is_ori) begin
                alu_src_c = 1'b1;
                alu_op_c  = 2'b10;
            end else if (is_lui) begin
                alu_src_c = 1'b1;
                alu_op_c  = 2'b11;
            end else if (is_lw || is_sw) begin
                alu_src_c = 1'b1;
                ext_op_c  = 1'b1;
            end else if (is_beq) begin
                alu_op_c = 2'b01;
            end
        end

        case (state)
            S_FETCH: begin
                ir_wr_c   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    is_jump_c = 1'b1;
                    pc_wr_c   = 1'b1;
                    state_nxt = S_FETCH;
                end else if (!is_legal) begin
                    illegal_set = 1'b1;
                    if (HALT_ON_ILLEGAL != 0) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_wr_c   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    npc_sel_c = 1'b1;
                    pc_wr_c   = 1'b1;
                    state_nxt = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_wr_c  = 1'b1;
                    pc_wr_c   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_wr_c     = 1'b1;
                pc_wr_c      = 1'b1;
                reg_dst_c    = is_r;
                mem_to_reg_c = is_lw;
                state_nxt    = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Combinational outputs are masked so nothing fires while reset is asserted.
    assign ir_wr      = ir_wr_c      & ~rst;
    assign pc_wr      = pc_wr_c      & ~rst;
    assign npc_sel    = npc_sel_c    & ~rst;
    assign is_jump    = is_jump_c    & ~rst;
    assign reg_wr     = reg_wr_c     & ~rst;
    assign reg_dst    = reg_dst_c    & ~rst;
    assign alu_src    = alu_src_c    & ~rst;
    assign alu_op     = rst ? 2'b00 : alu_op_c;
    assign ext_op     = ext_op_c     & ~rst;
    assign mem_wr     = mem_wr_c     & ~rst;
    assign mem_to_reg = mem_to_reg_c & ~rst;
    assign halted     = (state == S_HALT) & ~rst;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle control words, retire counting, illegal handling and reset.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_h;
    logic [31:0] ins;
    logic        alu_zero;

    logic ir_wr_m, pc_wr_m, npc_sel_m, is_jump_m, reg_wr_m, reg_dst_m, alu_src_m;
    logic ext_op_m, mem_wr_m, mem_to_reg_m, illegal_m, halted_m;
    logic [1:0]  alu_op_m;
    logic [31:0] retired_m;

    logic ir_wr_h, pc_wr_h, npc_sel_h, is_jump_h, reg_wr_h, reg_dst_h, alu_src_h;
    logic ext_op_h, mem_wr_h, mem_to_reg_h, illegal_h, halted_h;
    logic [1:0] alu_op_h;
    logic [1:0] retired_h;

    logic [11:0] ctrl_m, ctrl_h;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt_m  = 0;
    int cnt_h  = 0;

    always #5 clk = ~clk;

    mc_controller #(.CNT_W(32), .HALT_ON_ILLEGAL(0)) u_dut (
        .clk(clk), .rst(rst), .ins(ins), .alu_zero(alu_zero),
        .ir_wr(ir_wr_m), .pc_wr(pc_wr_m), .npc_sel(npc_sel_m), .is_jump(is_jump_m),
        .reg_wr(reg_wr_m), .reg_dst(reg_dst_m), .alu_src(alu_src_m), .alu_op(alu_op_m),
        .ext_op(ext_op_m), .mem_wr(mem_wr_m), .mem_to_reg(mem_to_reg_m),
        .illegal(illegal_m), .halted(halted_m), .retired(retired_m)
    );

    mc_controller #(.CNT_W(2), .HALT_ON_ILLEGAL(1)) u_dut_h (
        .clk(clk), .rst(rst_h), .ins(ins), .alu_zero(alu_zero),
        .ir_wr(ir_wr_h), .pc_wr(pc_wr_h), .npc_sel(npc_sel_h), .is_jump(is_jump_h),
        .reg_wr(reg_wr_h), .reg_dst(reg_dst_h), .alu_src(alu_src_h), .alu_op(alu_op_h),
        .ext_op(ext_op_h), .mem_wr(mem_wr_h), .mem_to_reg(mem_to_reg_h),
        .illegal(illegal_h), .halted(halted_h), .retired(retired_h)
    );

    // Bit order: ir_wr pc_wr npc_sel is_jump reg_wr reg_dst alu_src alu_op[1:0] ext_op mem_wr mem_to_reg
    assign ctrl_m = {ir_wr_m, pc_wr_m, npc_sel_m, is_jump_m, reg_wr_m, reg_dst_m,
                     alu_src_m, alu_op_m, ext_op_m, mem_wr_m, mem_to_reg_m};
    assign ctrl_h = {ir_wr_h, pc_wr_h, npc_sel_h, is_jump_h, reg_wr_h, reg_dst_h,
                     alu_src_h, alu_op_h, ext_op_h, mem_wr_h, mem_to_reg_h};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in a FETCH cycle, checks one control word per cycle, then the retire counter.
    task automatic run(input bit sel, input string tag, input logic [31:0] instr, input int n,
                       input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2,
                       input logic [11:0] e3, input logic [11:0] e4, input bit inc);
        logic [11:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        ins = instr;
        #1;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_c%0d", tag, k), {20'd0, (sel ? ctrl_h : ctrl_m)}, {20'd0, e[k]});
            step();
        end
        if (sel) begin
            if (inc) cnt_h = (cnt_h + 1) % 4;
            chk({tag, "_retired"}, {30'd0, retired_h}, cnt_h);
        end else begin
            if (inc) cnt_m = cnt_m + 1;
            chk({tag, "_retired"}, retired_m, cnt_m);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        rst_h    = 1'b1;
        ins      = 32'h0;
        alu_zero = 1'b0;
        #1;
        chk("rst_ctrl", {20'd0, ctrl_m}, 32'h0);
        chk("rst_retired", retired_m, 32'h0);
        chk("rst_illegal", {31'd0, illegal_m}, 32'h0);
        chk("rst_halted", {31'd0, halted_m}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        run(0, "addu", 32'h00221821, 4, 12'h800, 12'h000, 12'h000, 12'h4C0, 12'h000, 1);
        run(0, "subu", 32'h00221823, 4, 12'h800, 12'h000, 12'h008, 12'h4C8, 12'h000, 1);
        run(0, "lw",   32'h8C040008, 5, 12'h800, 12'h000, 12'h024, 12'h024, 12'h4A5, 1);
        run(0, "sw",   32'hAC040008, 4, 12'h800, 12'h000, 12'h024, 12'h426, 12'h000, 1);
        alu_zero = 1'b0;
        run(0, "beq_nz", 32'h10220003, 3, 12'h800, 12'h000, 12'h608, 12'h000, 12'h000, 1);
        alu_zero = 1'b1;
        run(0, "beq_z",  32'h10220003, 3, 12'h800, 12'h000, 12'h608, 12'h000, 12'h000, 1);
        alu_zero = 1'b0;
        run(0, "j",    32'h08000C05, 2, 12'h800, 12'h500, 12'h000, 12'h000, 12'h000, 1);
        run(0, "ori",  32'h3421FFFF, 4, 12'h800, 12'h000, 12'h030, 12'h4B0, 12'h000, 1);
        run(0, "lui",  32'h3C011234, 4, 12'h800, 12'h000, 12'h038, 12'h4B8, 12'h000, 1);
        chk("illegal_clear", {31'd0, illegal_m}, 32'h0);

        run(0, "ill_op", 32'hFC000000, 2, 12'h800, 12'h400, 12'h000, 12'h000, 12'h000, 1);
        chk("illegal_set", {31'd0, illegal_m}, 32'h1);
        run(0, "ill_fn", 32'h00221820, 2, 12'h800, 12'h400, 12'h000, 12'h000, 12'h000, 1);
        run(0, "addu2", 32'h00221821, 4, 12'h800, 12'h000, 12'h000, 12'h4C0, 12'h000, 1);
        chk("illegal_sticky", {31'd0, illegal_m}, 32'h1);
        chk("halted_never", {31'd0, halted_m}, 32'h0);

        // Reset in the middle of a load, while in MEM.
        ins = 32'h8C040008;
        #1;
        repeat (3) step();
        chk("lw_mem_pre", {20'd0, ctrl_m}, 32'h024);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {20'd0, ctrl_m}, 32'h0);
        chk("midrst_retired", retired_m, 32'h0);
        chk("midrst_illegal", {31'd0, illegal_m}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cnt_m = 0;
        chk("postrst_fetch", {20'd0, ctrl_m}, 32'h800);
        run(0, "addu3", 32'h00221821, 4, 12'h800, 12'h000, 12'h000, 12'h4C0, 12'h000, 1);

        // Halting variant with a 2-bit counter: five retires wrap to 1.
        @(negedge clk);
        rst_h = 1'b0;
        #1;
        run(1, "h_addu", 32'h00221821, 4, 12'h800, 12'h000, 12'h000, 12'h4C0, 12'h000, 1);
        run(1, "h_j",    32'h08000C05, 2, 12'h800, 12'h500, 12'h000, 12'h000, 12'h000, 1);
        run(1, "h_beq",  32'h10220003, 3, 12'h800, 12'h000, 12'h608, 12'h000, 12'h000, 1);
        run(1, "h_sw",   32'hAC040008, 4, 12'h800, 12'h000, 12'h024, 12'h426, 12'h000, 1);
        run(1, "h_lui",  32'h3C011234, 4, 12'h800, 12'h000, 12'h038, 12'h4B8, 12'h000, 1);
        chk("h_wrap", {30'd0, retired_h}, 32'h1);
        run(1, "h_ill",  32'hFC000000, 2, 12'h800, 12'h000, 12'h000, 12'h000, 12'h000, 0);
        chk("h_halted", {31'd0, halted_h}, 32'h1);
        chk("h_illegal", {31'd0, illegal_h}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("h_hold_%0d", i), {19'd0, halted_h, ctrl_h}, {19'd0, 1'b1, 12'h000});
            step();
        end
        chk("h_hold_retired", {30'd0, retired_h}, 32'h1);
        rst_h = 1'b1;
        #1;
        chk("h_rst_halted", {31'd0, halted_h}, 32'h0);
        chk("h_rst_illegal", {31'd0, illegal_h}, 32'h0);
        chk("h_rst_retired", {30'd0, retired_h}, 32'h0);
        @(negedge clk);
        rst_h = 1'b0;
        #1;
        chk("h_postrst_fetch", {20'd0, ctrl_h}, 32'h800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
